game_timer: RTL and testbench
=============================

# game_timer

Countdown timer that consumes the one-cycle tick pulses produced by the game's prescaler chain and converts them into a two-digit BCD seconds display plus a timeout event. It sits between the prescaler and the game control FSM. It loads a start time, decrements once per tick while running, and supports pause. It raises a one-cycle expiry pulse when the count reaches zero.

## Interface
Parameters:
- START_SECS, 60: value loaded on start; legal range 1..99.
- BONUS_SECS, 5: seconds added per bonus pulse; legal range 1..99; used only with bonus compiled in.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset; one clock; asynchronous, active-low; clears all state immediately.
- tick  input  1  one-cycle pulse, one per second, from the prescaler chain.
- start  input  1  pulse; reloads START_SECS and enters RUN from any state.
- pause  input  1  level; while high in RUN/PAUSE the count holds.
- bonus  input  1  pulse; adds BONUS_SECS (bonus build only; ignored otherwise).
- tens  output  4  BCD tens digit of remaining seconds.
- ones  output  4  BCD ones digit of remaining seconds.
- running  output  1  high in RUN state only.
- expired  output  1  one-cycle pulse on the cycle the count reaches zero.
- done  output  1  level, high in EXPIRED state.

## Operation
- Count held as two BCD digits, not binary; valid values 00..99.
- States: IDLE, RUN, PAUSE, EXPIRED.
  - IDLE: count shows 00. start → RUN with count = START_SECS.
  - RUN: tick with count > 1 → decrement by one, with a BCD borrow so that 10 goes to 09. pause=1 → PAUSE. tick with count == 1 → count 00, EXPIRED, and expired pulses.
  - PAUSE: count frozen, ticks ignored. pause=0 → RUN.
  - EXPIRED: count 00, done=1. Ticks and pause are ignored. start → RUN with reload.
- start has priority over every other input in every state. A tick in the same cycle as start is discarded.
- pause and tick in the same cycle in RUN: pause wins and no decrement happens.
- Bonus (bonus build only): accepted in RUN and PAUSE; ignored in IDLE and EXPIRED.
  - Result = count + BONUS_SECS, saturating at 99.
  - Bonus and tick in the same RUN cycle: result = min(99, count − 1 + BONUS_SECS). Expiry is not raised, even when count == 1.
- Reset values: tens=0, ones=0, running=0, expired=0, done=0, state IDLE.

## Timing
- Outputs are registered. A state or count change is visible on the cycle after the qualifying input edge.
- expired is high for exactly one cycle, the same cycle done first goes high.
- Reset asserted mid-run clears outputs asynchronously. After reset is released, the block remains in IDLE until start.
- Inputs are synchronous to clk; no internal synchronizers.

## Configuration
- GAME_TIMER_BONUS_EN defined: bonus port is functional and the BONUS_SECS saturating adder is built.
- Macro undefined: bonus is ignored, no adder logic exists, and BONUS_SECS is unused. All other behaviour is identical.

## Test plan
- Reset then start with START_SECS=60, followed by 60 ticks → display steps 60, 59 … 10, 09 … 01, 00. expired pulses once on the 60th tick; done=1 and running=0 thereafter.
- RUN at 42, pause=1 for 5 ticks then pause=0, then 1 tick → display holds 42, then shows 41. running is low during the pause.
- Tick coincident with start while in EXPIRED → display shows 60 and state is RUN. No decrement, and no second expired pulse.
- Bonus build at 97, bonus → 99. At 03, bonus and tick in the same cycle → 07. At 01, bonus and tick together → 05 with no expired pulse.
- Non-bonus build at 30, bonus pulses → display stays 30.
- Reset asserted mid-run at 25, asynchronously between clock edges → outputs go to zero before the next edge. Later ticks are ignored until start.

Source files
------------

// File: rtl/game_timer.sv
// rtl/game_timer.sv - BCD countdown timer driven by 1 Hz ticks, with pause and expiry pulse.
// Optional bonus adder built only when GAME_TIMER_BONUS_EN is defined.
module game_timer #(
  parameter int unsigned START_SECS = 60,
  parameter int unsigned BONUS_SECS = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       bonus_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       running_o,
  output logic       expired_o,
  output logic       done_o
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

  localparam logic [3:0] START_TENS = 4'(START_SECS / 10);
  localparam logic [3:0] START_ONES = 4'(START_SECS % 10);

  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       expired_q, expired_d;

  logic       cnt_is_one;
  logic [3:0] dec_tens, dec_ones;
  logic       bonus_hit;
  logic [3:0] bon_tens, bon_ones;

  assign cnt_is_one = (tens_q == 4'd0) && (ones_q == 4'd1);

  // BCD decrement: a zero ones digit borrows from tens (10 -> 09)
  always_comb begin
    dec_tens = tens_q;
    dec_ones = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_tens = tens_q - 4'd1;
      dec_ones = 4'd9;
    end
  end

`ifdef GAME_TIMER_BONUS_EN
  logic [6:0] cnt_bin, base_bin, sat_bin;
  logic [7:0] sum_bin;

  // A tick coinciding with bonus in RUN is folded in as count-1 before adding
  always_comb begin
    cnt_bin  = ({3'b000, tens_q} * 7'd10) + {3'b000, ones_q};
    base_bin = (tick_i && (state_q == RUN) && !pause_i) ? cnt_bin - 7'd1 : cnt_bin;
    sum_bin  = {1'b0, base_bin} + 8'(BONUS_SECS);
    sat_bin  = (sum_bin > 8'd99) ? 7'd99 : sum_bin[6:0];
    bon_tens = 4'(sat_bin / 7'd10);
    bon_ones = 4'(sat_bin % 7'd10);
  end

  assign bonus_hit = bonus_i;
`else
  localparam int unsigned unused_bonus_secs = BONUS_SECS;
  logic unused_bonus;

  assign unused_bonus = bonus_i;
  assign bonus_hit    = 1'b0;
  assign bon_tens     = tens_q;
  assign bon_ones     = ones_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    expired_d = 1'b0;
    if (start_i) begin
      state_d = RUN;
      tens_d  = START_TENS;
      ones_d  = START_ONES;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (bonus_hit) begin
            tens_d = bon_tens;
            ones_d = bon_ones;
            if (pause_i) state_d = PAUSE;
          end else if (pause_i) begin
            state_d = PAUSE;
          end else if (tick_i) begin
            if (cnt_is_one) begin
              tens_d    = 4'd0;
              ones_d    = 4'd0;
              state_d   = EXPIRED;
              expired_d = 1'b1;
            end else begin
              tens_d = dec_tens;
              ones_d = dec_ones;
            end
          end
        end
        PAUSE: begin
          if (bonus_hit) begin
            tens_d = bon_tens;
            ones_d = bon_ones;
          end
          if (!pause_i) state_d = RUN;
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tens_o    = tens_q;
    ones_o    = ones_q;
    running_o = (state_q == RUN);
    done_o    = (state_q == EXPIRED);
    expired_o = expired_q;
  end

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - randomized self-checking bench for game_timer against a seconds-level model.
module tb_game_timer;

  localparam int START = 60;
  localparam int BSECS = 5;
`ifdef GAME_TIMER_BONUS_EN
  localparam bit BON_EN = 1'b1;
`else
  localparam bit BON_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0, start = 1'b0, pause = 1'b0, bonus = 1'b0;
  logic [3:0] tens, ones;
  logic running, expired, done;

  game_timer #(.START_SECS(START), .BONUS_SECS(BSECS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_i(start), .pause_i(pause),
    .bonus_i(bonus), .tens_o(tens), .ones_o(ones), .running_o(running),
    .expired_o(expired), .done_o(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  // Model: remaining seconds as an integer; mode 0 idle, 1 counting, 2 held, 3 timed out
  int m_cnt = 0;
  int m_mode = 0;
  bit m_exp = 1'b0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("tens", 32'(tens), 32'(m_cnt / 10));
      check("ones", 32'(ones), 32'(m_cnt % 10));
      check("running", 32'(running), 32'(m_mode == 1));
      check("expired", 32'(expired), 32'(m_exp));
      check("done", 32'(done), 32'(m_mode == 3));
    end
  end

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_exp = 1'b0;
  endtask

  function automatic int add_bonus(input int base);
    return (base + BSECS > 99) ? 99 : base + BSECS;
  endfunction

  task automatic model_step(input bit t, input bit s, input bit p, input bit b);
    m_exp = 1'b0;
    if (s) begin
      m_mode = 1; m_cnt = START;
    end else if (m_mode == 1) begin
      if (p) begin
        if (BON_EN && b) m_cnt = add_bonus(m_cnt);
        m_mode = 2;
      end else if (BON_EN && b) begin
        m_cnt = add_bonus(m_cnt - int'(t));
      end else if (t) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_mode = 3; m_exp = 1'b1; end
      end
    end else if (m_mode == 2) begin
      if (BON_EN && b) m_cnt = add_bonus(m_cnt);
      if (!p) m_mode = 1;
    end
  endtask

  task automatic step(input bit t, input bit s, input bit p, input bit b);
    tick = t; start = s; pause = p; bonus = b;
    @(posedge clk);
    if (rst_n) model_step(t, s, p, b);
    else model_reset();
    #1;
  endtask

  task automatic lit(input string n, input int et, input int eo, input int er, input int ee, input int ed);
    check({n, ".tens"}, 32'(tens), 32'(et));
    check({n, ".ones"}, 32'(ones), 32'(eo));
    check({n, ".running"}, 32'(running), 32'(er));
    check({n, ".expired"}, 32'(expired), 32'(ee));
    check({n, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 lit("async_rst", 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit p_lvl;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    lit("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    lit("idle_tick", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    lit("start", 6, 0, 1, 0, 0);
    for (int i = 1; i <= 60; i++) begin
      step(1, 0, 0, 0);
      if (i == 1)  lit("t1", 5, 9, 1, 0, 0);
      if (i == 50) lit("t50", 1, 0, 1, 0, 0);
      if (i == 51) lit("t51", 0, 9, 1, 0, 0);
      if (i == 60) lit("t60", 0, 0, 0, 1, 1);
    end
    step(1, 0, 1, 0);
    lit("after_exp", 0, 0, 0, 0, 1);
    step(1, 1, 0, 0);
    lit("tick_start_exp", 6, 0, 1, 0, 0);
    for (int i = 0; i < 18; i++) step(1, 0, 0, 0);
    lit("at42", 4, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
    lit("paused", 4, 2, 0, 0, 0);
    step(0, 0, 0, 0);
    lit("resume", 4, 2, 1, 0, 0);
    step(1, 0, 0, 0);
    lit("t41", 4, 1, 1, 0, 0);
    step(0, 0, 0, 1);
    lit("bonus41", 4, BON_EN ? 6 : 1, 1, 0, 0);
    n = (BON_EN ? 46 : 41) - 25;
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    lit("at25", 2, 5, 1, 0, 0);
    async_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    lit("post_rst_idle", 0, 0, 0, 0, 0);

    p_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) p_lvl = ~p_lvl;
      if ($urandom_range(0, 699) == 0) async_reset();
      else step($urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0, p_lvl,
                $urandom_range(0, 11) == 0);
    end
    step(0, 0, 0, 0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
